// File: rtl/cim_pkg.sv
// ============================================================================
// Module  : cim_pkg
// Brief   : Shared types and helpers for the CIM crossbar tile.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } cim_tile_state_t;

  function automatic int cim_acc_size(input int datatype_size, input int xbar_size);
    return 2 * datatype_size + $clog2(xbar_size);
  endfunction

  // Clamp an unsigned accumulator to the largest datatype_size-bit value.
  function automatic logic [31:0] cim_sat(input logic [31:0] acc, input int unsigned datatype_size);
    logic [31:0] max_v;
    max_v = (32'd1 << datatype_size) - 32'd1;
    return (acc > max_v) ? max_v : acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cim_col_mac.sv
// ============================================================================
// Module  : cim_col_mac
// Brief   : Combinational dot product of the input row with one weight column.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cim_col_mac
  import cim_pkg::*;
#(
  parameter int xbar_size     = 128,
  parameter int datatype_size = 2,
  parameter int acc_size      = cim_acc_size(datatype_size, xbar_size)
) (
  input  logic [xbar_size*datatype_size-1:0] i_in_vec,
  input  logic [xbar_size*datatype_size-1:0] i_wt_col,
  output logic [acc_size-1:0]                o_acc
);

  // Operands are widened before the multiply so nothing is truncated.
  always_comb begin
    o_acc = '0;
    for (int r = 0; r < xbar_size; r++) begin
      o_acc = o_acc + (acc_size'(i_in_vec[r*datatype_size +: datatype_size]) *
                       acc_size'(i_wt_col[r*datatype_size +: datatype_size]));
    end
  end

endmodule

`default_nettype wire

// File: rtl/cim_xbar_tile.sv
// ============================================================================
// Module  : cim_xbar_tile
// Brief   : Compute-in-memory crossbar tile: timed MVM, one column per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cim_xbar_tile
  import cim_pkg::*;
#(
  parameter int xbar_size     = 128,
  parameter int datatype_size = 2,
  parameter int settle_cycles = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
  input  logic [datatype_size-1:0]     i_wr_data,
  input  logic                         i_wt_we,
  input  logic [$clog2(xbar_size)-1:0] i_wt_row,
  input  logic [$clog2(xbar_size)-1:0] i_wt_col,
  input  logic [datatype_size-1:0]     i_wt_data,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
  output logic [datatype_size-1:0]     o_data
);

  localparam int c_ADDR_W   = $clog2(xbar_size);
  localparam int c_ACC_SIZE = cim_acc_size(datatype_size, xbar_size);
  localparam int c_CNT_W    = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  localparam logic [c_CNT_W-1:0]  c_SETTLE_LOAD = c_CNT_W'(settle_cycles - 1);
  localparam logic [c_ADDR_W-1:0] c_LAST_COL    = c_ADDR_W'(xbar_size - 1);

  cim_tile_state_t             r_state;
  logic [c_CNT_W-1:0]          r_cnt;
  logic [c_ADDR_W-1:0]         r_col;
  logic                        r_busy;
  logic                        r_done;
  logic [datatype_size-1:0]    r_data;

  logic [datatype_size-1:0]    r_in_buf  [xbar_size];
  logic [datatype_size-1:0]    r_wt      [xbar_size][xbar_size];
  logic [datatype_size-1:0]    r_out_buf [xbar_size];

  logic [xbar_size*datatype_size-1:0] w_in_vec;
  logic [xbar_size*datatype_size-1:0] w_wt_col;
  logic [c_ACC_SIZE-1:0]              w_acc;
  logic [datatype_size-1:0]           w_sat;
  logic                               w_accept;
  logic                               w_wr_ok;
  logic                               w_wt_ok;
  logic                               w_rd_ok;

  // Address range checks only matter when xbar_size is not a power of two.
  if ((1 << c_ADDR_W) == xbar_size) begin : g_pow2
    assign w_wr_ok = 1'b1;
    assign w_wt_ok = 1'b1;
    assign w_rd_ok = 1'b1;
  end else begin : g_npow2
    assign w_wr_ok = ({1'b0, i_wr_addr} < (c_ADDR_W+1)'(xbar_size));
    assign w_wt_ok = ({1'b0, i_wt_row} < (c_ADDR_W+1)'(xbar_size)) &&
                     ({1'b0, i_wt_col} < (c_ADDR_W+1)'(xbar_size));
    assign w_rd_ok = ({1'b0, i_rd_addr} < (c_ADDR_W+1)'(xbar_size));
  end

  for (genvar r = 0; r < xbar_size; r++) begin : g_pack
    assign w_in_vec[r*datatype_size +: datatype_size] = r_in_buf[r];
    assign w_wt_col[r*datatype_size +: datatype_size] = r_wt[r][r_col];
  end

  cim_col_mac #(
    .xbar_size     (xbar_size),
    .datatype_size (datatype_size),
    .acc_size      (c_ACC_SIZE)
  ) u_col_mac (
    .i_in_vec (w_in_vec),
    .i_wt_col (w_wt_col),
    .o_acc    (w_acc)
  );

  assign w_sat    = datatype_size'(cim_sat(32'(w_acc), datatype_size));
  assign w_accept = (r_state == ST_IDLE) || (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < xbar_size; r++) begin
        r_in_buf[r]  <= '0;
        r_out_buf[r] <= '0;
        for (int c = 0; c < xbar_size; c++) begin
          r_wt[r][c] <= '0;
        end
      end
      r_data <= '0;
    end else begin
      if (w_accept && i_wr_en && w_wr_ok) begin
        r_in_buf[i_wr_addr] <= i_wr_data;
      end
      if (w_accept && i_wt_we && w_wt_ok) begin
        r_wt[i_wt_row][i_wt_col] <= i_wt_data;
      end
      if (r_state == ST_COMPUTE) begin
        r_out_buf[r_col] <= w_sat;
      end
      r_data <= w_rd_ok ? r_out_buf[i_rd_addr] : '0;
    end
  end

  // busy/done are registered alongside the state so they never see i_start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_col   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state <= ST_SETTLE;
            r_cnt   <= c_SETTLE_LOAD;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_COMPUTE;
            r_col   <= '0;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        ST_COMPUTE: begin
          if (r_col == c_LAST_COL) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_col <= r_col + c_ADDR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: doc/cim_xbar_tile.md
# cim_xbar_tile

Cycle-level behavioural model of one compute-in-memory crossbar tile: the responder on the far side of the `o_cim_wr_addr` / `o_cim_data` / `i_cim_busy` / `o_cim_rd_addr` / `i_data` interface driven by `conv_layer` and `fc_layer`. It latches one input row of `xbar_size` activations written by the layer and holds a `xbar_size` x `xbar_size` weight array. On a start pulse it runs a timed matrix-vector multiply, one column per cycle, and signals busy for the duration. The layer then reads the column results back by address. One instance sits at each (v, h) tile position of every CIM layer in the perf-sim top.

## Interface
- `xbar_size`, 128: rows = columns of the crossbar.
- `datatype_size`, 2: width of activations, weights and results (unsigned).
- `settle_cycles`, 4: analog settle cycles before the column sweep; must be ≥ 1.
- `acc_size`, 2*datatype_size+$clog2(xbar_size): accumulator width; derived, not overridden.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_wr_en`  in  1  input-row write strobe.
- `i_wr_addr`  in  $clog2(xbar_size)  input-row index.
- `i_wr_data`  in  datatype_size  activation value.
- `i_wt_we`  in  1  weight programming strobe.
- `i_wt_row`, `i_wt_col`  in  $clog2(xbar_size) each  weight cell address.
- `i_wt_data`  in  datatype_size  weight value.
- `i_start`  in  1  single-cycle MVM start pulse.
- `o_busy`  out  1  MVM in progress; connects to the layer's `i_cim_busy`.
- `o_done`  out  1  one-cycle completion pulse.
- `i_rd_addr`  in  $clog2(xbar_size)  result column index.
- `o_data`  out  datatype_size  registered result for `i_rd_addr`; connects to the layer's `i_data` entry.

## Operation
- Storage:
  - `in_buf[xbar_size]`: activations.
  - `wt[xbar_size][xbar_size]`: weights.
  - `out_buf[xbar_size]`: results.
  - All storage is zeroed by reset.
- FSM `IDLE → SETTLE → COMPUTE → DONE → IDLE`.
- IDLE:
  - `i_wr_en` writes `in_buf[i_wr_addr]`.
  - `i_wt_we` writes `wt[i_wt_row][i_wt_col]`.
  - `i_start` moves to SETTLE and loads the settle counter with `settle_cycles-1`.
- SETTLE: count down to 0, then enter COMPUTE with column counter `col=0`.
- COMPUTE, each cycle:
  - `acc = Σ_r in_buf[r]*wt[r][col]`, computed at full `acc_size` width with no intermediate truncation.
  - `out_buf[col] = (acc > 2^datatype_size-1) ? 2^datatype_size-1 : acc`, i.e. saturating.
  - `col` increments; after `col = xbar_size-1`, go to DONE.
- DONE:
  - Lasts one cycle with `o_done=1`.
  - `i_wr_en` and `i_wt_we` are accepted as in IDLE.
  - `i_start` goes directly to SETTLE (back-to-back operation).
  - Otherwise returns to IDLE.
- While in SETTLE or COMPUTE:
  - `i_wr_en`, `i_wt_we` and `i_start` are ignored and dropped, with no queuing.
  - Reads of columns not yet recomputed return the previous result.
- `i_wr_en` and `i_start` in the same IDLE cycle: the write lands, and the MVM uses the new value.
- Out-of-range addresses (possible only when `xbar_size` is not a power of 2): writes are dropped and reads return 0.

## Timing
- Reset values: `o_busy=0`, `o_done=0`, `o_data=0`, FSM=IDLE.
- Reset asserted mid-operation aborts immediately, with all outputs and storage cleared.
- `i_start` sampled at edge t:
  - `o_busy=1` for cycles t+1 … t+settle_cycles+xbar_size.
  - `o_done=1` and `o_busy=0` at cycle t+settle_cycles+xbar_size+1.
- `o_busy` is purely state-decoded, with no combinational path from `i_start`.
- Read latency is 1 cycle: `o_data` at edge t+1 reflects `out_buf[i_rd_addr]` as sampled at edge t.
- A read of column c in the same cycle that c is written returns the old value.
- Busy duration per MVM = settle_cycles + xbar_size cycles (132 at defaults).

## Structure
- `cim_pkg` holds:
  - the FSM state enum `cim_tile_state_t`;
  - the function `cim_acc_size(datatype_size, xbar_size)`;
  - the saturation function `cim_sat`.
- Sub-module `cim_col_mac`: purely combinational dot product of `in_buf` with one weight column, output `acc_size` wide. It is instanced once in `cim_xbar_tile` and reused across columns via `col`.

## Test plan
Bench uses `xbar_size=4`, `datatype_size=2`, `settle_cycles=4`.
- Reset: release `rst`, then read addresses 0–3 → `o_data=0` each; `o_busy=0`, `o_done=0`.
- Identity weights, inputs {1,2,3,0}, `i_start` → `o_busy` high exactly 8 cycles, `o_done` pulse on the 9th cycle, reads return {1,2,3,0}.
- Saturation: all weights 3, all inputs 3 (acc=36) → every column reads 3. All weights 0 → every column reads 0.
- Protection: during busy, write `in_buf[0]=3` and pulse `i_start` → ignored. Results match pre-write inputs, and busy lasts 8 cycles only.
- Back-to-back: `i_start` in the `o_done` cycle → `o_busy` high again the next cycle for 8 cycles.
- Async reset at COMPUTE column 2 → `o_busy=0` without waiting for a clock edge; after release, every column reads 0.
